// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types for the register-file writeback queue: default widths and the queued entry format.
// Optional forwarding lookup is enabled elsewhere with the WB_FORWARD_EN macro.
package wb_pkg;

   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;

   localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Bus between the execute/memory producers, the register-file write port and the queue.
// Forwarding lookup signals exist only when WB_FORWARD_EN is defined.
interface regfile_writeback_queue_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);

   logic                    alu_valid;
   logic                    alu_ready;
   logic [ADDR_W-1:0]       alu_rd;
   logic [DATA_W-1:0]       alu_data;
   logic                    ld_valid;
   logic                    ld_ready;
   logic [ADDR_W-1:0]       ld_rd;
   logic [DATA_W-1:0]       ld_data;
   logic                    wb_stall;
   logic                    reg_write;
   logic [ADDR_W-1:0]       write_reg;
   logic [DATA_W-1:0]       write_data;
   logic [$clog2(DEPTH):0]  count;
   logic                    busy;
`ifdef WB_FORWARD_EN
   logic [ADDR_W-1:0]       fwd_rs1;
   logic [ADDR_W-1:0]       fwd_rs2;
   logic                    fwd_hit1;
   logic                    fwd_hit2;
   logic [DATA_W-1:0]       fwd_data1;
   logic [DATA_W-1:0]       fwd_data2;
`endif

   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wb_stall,
      input  alu_ready, ld_ready, reg_write, write_reg, write_data, count, busy
`ifdef WB_FORWARD_EN
      , output fwd_rs1, fwd_rs2
      , input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wb_stall,
      output alu_ready, ld_ready, reg_write, write_reg, write_data, count, busy
`ifdef WB_FORWARD_EN
      , input  fwd_rs1, fwd_rs2
      , output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
   );

endinterface

// File: rtl/regfile_writeback_queue_fifo.sv
// Generic in-order FIFO of writeback entries with occupancy count and head view.
// With WB_FORWARD_EN defined it also exposes its storage and head pointer for lookups.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  wb_entry_t                push_entry,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
`ifdef WB_FORWARD_EN
   , output wb_entry_t              entries [DEPTH]
   , output logic [$clog2(DEPTH)-1:0] head_ptr
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers rely on DEPTH being a power of two so they wrap for free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

`ifdef WB_FORWARD_EN
   assign entries  = mem;
   assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue feeding the register file write port from the ALU and load paths (load wins).
// Define WB_FORWARD_EN to add a two-port youngest-match forwarding lookup over queued entries.
module regfile_writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   regfile_writeback_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (ADDR_W != WB_ADDR_W || DATA_W != WB_DATA_W) begin : g_width_check
      $error("regfile_writeback_queue widths must match wb_pkg entry layout");
   end

   wb_entry_t         push_entry;
   wb_entry_t         head;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              ld_fire;
   logic              alu_fire;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_rd;
   logic [DATA_W-1:0] push_data;

   // One push per cycle; a full queue refuses both sources even if it drains this cycle.
   assign bus.ld_ready  = !full;
   assign bus.alu_ready = !full && !bus.ld_valid;
   assign ld_fire       = bus.ld_valid && !full;
   assign alu_fire      = bus.alu_valid && !full && !bus.ld_valid;
   assign push_rd       = ld_fire ? bus.ld_rd   : bus.alu_rd;
   assign push_data     = ld_fire ? bus.ld_data : bus.alu_data;
   assign push_entry    = '{rd: push_rd, data: push_data};
   assign push          = (ld_fire || alu_fire) && (push_rd != REG_ZERO);

   assign pop            = !empty && !bus.wb_stall;
   assign bus.reg_write  = pop;
   assign bus.write_reg  = pop ? head.rd   : '0;
   assign bus.write_data = pop ? head.data : '0;
   assign bus.count      = count;
   assign bus.busy       = !empty;

`ifdef WB_FORWARD_EN
   wb_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head_ptr;
`endif

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count),
      .full       (full),
      .empty      (empty)
`ifdef WB_FORWARD_EN
      , .entries  (entries)
      , .head_ptr (head_ptr)
`endif
   );

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the last match overwrites earlier ones.
   always_comb begin
      bus.fwd_hit1  = 1'b0;
      bus.fwd_hit2  = 1'b0;
      bus.fwd_data1 = '0;
      bus.fwd_data2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < count) begin
            if (bus.fwd_rs1 != REG_ZERO && entries[head_ptr + PTR_W'(k)].rd == bus.fwd_rs1) begin
               bus.fwd_hit1  = 1'b1;
               bus.fwd_data1 = entries[head_ptr + PTR_W'(k)].data;
            end
            if (bus.fwd_rs2 != REG_ZERO && entries[head_ptr + PTR_W'(k)].rd == bus.fwd_rs2) begin
               bus.fwd_hit2  = 1'b1;
               bus.fwd_data2 = entries[head_ptr + PTR_W'(k)].data;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios then random traffic against a queue model.
// Forwarding checks are compiled in when WB_FORWARD_EN is defined.
module tb_regfile_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } ref_t;

   logic clk = 1'b0;
   logic reset_n;
   ref_t ref_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   regfile_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, check every output against the model, then advance the model.
   task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                                input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ldd,
                                input logic st);
      logic full_now, exp_ld_ready, exp_alu_ready, exp_write;
      @(negedge clk);
      bus.alu_valid = av;
      bus.alu_rd    = ar;
      bus.alu_data  = ad;
      bus.ld_valid  = lv;
      bus.ld_rd     = lr;
      bus.ld_data   = ldd;
      bus.wb_stall  = st;
      #1;
      full_now      = (ref_q.size() >= DEPTH);
      exp_ld_ready  = !full_now;
      exp_alu_ready = !full_now && !lv;
      exp_write     = (ref_q.size() != 0) && !st;
      checkOutput("count",      64'(bus.count),      64'(ref_q.size()));
      checkOutput("busy",       64'(bus.busy),       64'(ref_q.size() != 0));
      checkOutput("ld_ready",   64'(bus.ld_ready),   64'(exp_ld_ready));
      checkOutput("alu_ready",  64'(bus.alu_ready),  64'(exp_alu_ready));
      checkOutput("reg_write",  64'(bus.reg_write),  64'(exp_write));
      checkOutput("write_reg",  64'(bus.write_reg),  exp_write ? 64'(ref_q[0].rd)   : 64'd0);
      checkOutput("write_data", 64'(bus.write_data), exp_write ? 64'(ref_q[0].data) : 64'd0);
`ifdef WB_FORWARD_EN
      begin
         logic hit1 = 1'b0, hit2 = 1'b0;
         logic [DATA_W-1:0] d1 = '0, d2 = '0;
         foreach (ref_q[i]) begin
            if (bus.fwd_rs1 != 0 && ref_q[i].rd == bus.fwd_rs1) begin hit1 = 1'b1; d1 = ref_q[i].data; end
            if (bus.fwd_rs2 != 0 && ref_q[i].rd == bus.fwd_rs2) begin hit2 = 1'b1; d2 = ref_q[i].data; end
         end
         checkOutput("fwd_hit1",  64'(bus.fwd_hit1),  64'(hit1));
         checkOutput("fwd_data1", 64'(bus.fwd_data1), 64'(d1));
         checkOutput("fwd_hit2",  64'(bus.fwd_hit2),  64'(hit2));
         checkOutput("fwd_data2", 64'(bus.fwd_data2), 64'(d2));
      end
`endif
      @(posedge clk);
      if (exp_write) void'(ref_q.pop_front());
      if (lv && exp_ld_ready) begin
         if (lr != 0) ref_q.push_back('{rd: lr, data: ldd});
      end else if (av && exp_alu_ready && ar != 0) begin
         ref_q.push_back('{rd: ar, data: ad});
      end
   endtask

   task automatic idle(input logic st);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, st);
   endtask

`ifdef WB_FORWARD_EN
   task automatic setForward(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
      bus.fwd_rs1 = r1;
      bus.fwd_rs2 = r2;
   endtask
`endif

   initial begin
      reset_n       = 1'b0;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = '0;
      bus.ld_data   = '0;
      bus.wb_stall  = 1'b0;
`ifdef WB_FORWARD_EN
      setForward('0, '0);
`endif
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_count",     64'(bus.count),      64'd0);
      checkOutput("rst_busy",      64'(bus.busy),       64'd0);
      checkOutput("rst_reg_write", 64'(bus.reg_write),  64'd0);
      checkOutput("rst_write_reg", 64'(bus.write_reg),  64'd0);
      checkOutput("rst_wdata",     64'(bus.write_data), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("rst_ld_ready",  64'(bus.ld_ready),  64'd1);
      checkOutput("rst_alu_ready", 64'(bus.alu_ready), 64'd1);

      // Single ALU result appears on the write port the next cycle.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
      #1;
      checkOutput("t1_reg_write",  64'(bus.reg_write),  64'd1);
      checkOutput("t1_write_reg",  64'(bus.write_reg),  64'd5);
      checkOutput("t1_write_data", 64'(bus.write_data), 64'hDEADBEEF);
      idle(1'b0);
      #1;
      checkOutput("t1_count", 64'(bus.count), 64'd0);

      // Load beats ALU in the same cycle; ALU goes next.
      applyStimulus(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0);
      applyStimulus(1'b1, 5'd4, 32'h22, 1'b0, '0, '0, 1'b0);
      #1;
      checkOutput("t2_write_reg", 64'(bus.write_reg), 64'd4);
      idle(1'b0);

      // Fill under stall, hold a fifth request, then drain.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(i + 10), 32'(100 + i), 1'b0, '0, '0, 1'b1);
      applyStimulus(1'b1, 5'd20, 32'd200, 1'b0, '0, '0, 1'b1);
      #1;
      checkOutput("t3_full_count", 64'(bus.count), 64'd4);
      applyStimulus(1'b1, 5'd20, 32'd200, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 6; i++) idle(1'b0);

      // x0 destination is acknowledged but discarded.
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0);
      #1;
      checkOutput("t4_count",     64'(bus.count),     64'd0);
      checkOutput("t4_reg_write", 64'(bus.reg_write), 64'd0);
      idle(1'b0);

`ifdef WB_FORWARD_EN
      applyStimulus(1'b1, 5'd7, 32'h1, 1'b0, '0, '0, 1'b1);
      applyStimulus(1'b1, 5'd7, 32'h2, 1'b0, '0, '0, 1'b1);
      setForward(5'd7, 5'd0);
      idle(1'b1);
      #1;
      checkOutput("t5_hit1",  64'(bus.fwd_hit1),  64'd1);
      checkOutput("t5_data1", 64'(bus.fwd_data1), 64'd2);
      checkOutput("t5_hit2",  64'(bus.fwd_hit2),  64'd0);
      for (int i = 0; i < 3; i++) idle(1'b0);
`endif

      // Asynchronous reset mid-cycle with entries pending.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'(i + 1), 32'(i + 50), 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      bus.alu_valid = 1'b0;
      bus.wb_stall  = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_count",     64'(bus.count),     64'd0);
      checkOutput("t6_reg_write", 64'(bus.reg_write), 64'd0);
      ref_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b0);

      // Random mixed traffic.
      for (int n = 0; n < 600; n++) begin
`ifdef WB_FORWARD_EN
         setForward(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
`endif
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
